multicycle_ctrl: RTL and testbench

Main control FSM for the multicycle MIPS datapath. It decodes the 6-bit opcode and sequences fetch, decode, execute, memory and write-back. It drives every datapath enable, including the 2-bit ALU operation class (alu_op1/alu_op0) that the downstream ALU control decoder combines with the funct field. Memory accesses use a ready handshake, so variable-latency memory stalls the sequence.

---
 rtl/cpu_ctrl_pkg.sv | 41 ++++
 rtl/multicycle_ctrl_outdec.sv | 90 +++++++++
 rtl/multicycle_ctrl.sv | 90 +++++++++
 tb/tb_multicycle_ctrl.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, FSM states,
// ALU operation classes and datapath mux selects.
package cpu_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEM_ADDR = 4'd3,
        S_MEM_RD   = 4'd4,
        S_MEM_WB   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_R_EXEC   = 4'd7,
        S_R_WB     = 4'd8,
        S_BRANCH   = 4'd9,
        S_JUMP     = 4'd10,
        S_I_EXEC   = 4'd11,
        S_I_WB     = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_RT      = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/multicycle_ctrl_outdec.sv
// Combinational state-to-datapath-control decoder for the multicycle FSM.
// Only FETCH looks at memory readiness, so the IR/PC load waits for the word.
module multicycle_ctrl_outdec
    import cpu_ctrl_pkg::*;
(
    input  state_t     state,
    input  logic       mem_rdy,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       alu_op1,
    output logic       alu_op0,
    output logic [1:0] pc_source
);

    logic [1:0] alu_op;

    assign alu_op1 = alu_op[1];
    assign alu_op0 = alu_op[0];

    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_RT;
        alu_op        = ALUOP_ADD;
        pc_source     = PCSRC_ALU;
        unique case (state)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                ir_write  = mem_rdy;
                pc_write  = mem_rdy;
            end
            S_DECODE: alu_src_b = SRCB_IMM_SH2;
            S_MEM_ADDR, S_I_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
            end
            S_R_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_FUNCT;
            end
            S_R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_I_WB: reg_write = 1'b1;
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = ALUOP_SUB;
                pc_write_cond = 1'b1;
                pc_source     = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = PCSRC_JUMP;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle MIPS datapath: holds the state register
// and next-state logic; datapath controls come from multicycle_ctrl_outdec.
module multicycle_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int MEM_HANDSHAKE = 1,
    parameter int STATE_W       = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5:0]         opcode,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               pc_write_cond,
    output logic               i_or_d,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic               mem_to_reg,
    output logic               reg_dst,
    output logic               reg_write,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic               alu_op1,
    output logic               alu_op0,
    output logic [1:0]         pc_source,
    output logic               illegal_op,
    output logic [STATE_W-1:0] state_dbg
);

    state_t state_q, state_d;
    logic   mem_rdy;

    assign mem_rdy   = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;
    assign state_dbg = STATE_W'(state_q);

    always_comb begin
        state_d    = state_q;
        illegal_op = 1'b0;
        unique case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH:  if (mem_rdy) state_d = S_DECODE;
            S_DECODE: begin
                unique case (opcode)
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_RTYPE:     state_d = S_R_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_I_EXEC;
                    default: begin
                        illegal_op = 1'b1;
                        state_d    = S_FETCH;
                    end
                endcase
            end
            S_MEM_ADDR: state_d = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   if (mem_rdy) state_d = S_MEM_WB;
            S_MEM_WR:   if (mem_rdy) state_d = S_FETCH;
            S_R_EXEC:   state_d = S_R_WB;
            S_I_EXEC:   state_d = S_I_WB;
            S_MEM_WB, S_R_WB, S_I_WB, S_BRANCH, S_JUMP: state_d = S_FETCH;
            default:    state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    multicycle_ctrl_outdec u_outdec (
        .state         (state_q),
        .mem_rdy       (mem_rdy),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .i_or_d        (i_or_d),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .mem_to_reg    (mem_to_reg),
        .reg_dst       (reg_dst),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op1       (alu_op1),
        .alu_op0       (alu_op0),
        .pc_source     (pc_source)
    );

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: each stimulus cycle queues the expected
// state and control vector; a negedge monitor pops and compares.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a, alu_op1, alu_op0;
    logic [1:0] alu_src_b, pc_source;
    logic       illegal_op;
    logic [3:0] state_dbg;

    multicycle_ctrl #(.MEM_HANDSHAKE(1), .STATE_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op1(alu_op1),
        .alu_op0(alu_op0), .pc_source(pc_source), .illegal_op(illegal_op),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    // Control vector bit layout, MSB first:
    // pw pwc iod mr mw irw m2r rdst rw asa asb[1:0] op1 op0 ps[1:0] ill
    localparam logic [16:0] M_PW    = 17'h1 << 16;
    localparam logic [16:0] M_PWC   = 17'h1 << 15;
    localparam logic [16:0] M_IOD   = 17'h1 << 14;
    localparam logic [16:0] M_MR    = 17'h1 << 13;
    localparam logic [16:0] M_MW    = 17'h1 << 12;
    localparam logic [16:0] M_IRW   = 17'h1 << 11;
    localparam logic [16:0] M_M2R   = 17'h1 << 10;
    localparam logic [16:0] M_RDST  = 17'h1 << 9;
    localparam logic [16:0] M_RW    = 17'h1 << 8;
    localparam logic [16:0] M_ASA   = 17'h1 << 7;
    localparam logic [16:0] M_ASB01 = 17'h1 << 5;
    localparam logic [16:0] M_ASB10 = 17'h2 << 5;
    localparam logic [16:0] M_ASB11 = 17'h3 << 5;
    localparam logic [16:0] M_OP1   = 17'h1 << 4;
    localparam logic [16:0] M_OP0   = 17'h1 << 3;
    localparam logic [16:0] M_PS01  = 17'h1 << 1;
    localparam logic [16:0] M_PS10  = 17'h2 << 1;
    localparam logic [16:0] M_ILL   = 17'h1;

    localparam logic [16:0] E_IDLE   = 17'h0;
    localparam logic [16:0] E_FETCH  = M_PW | M_MR | M_IRW | M_ASB01;
    localparam logic [16:0] E_FSTALL = M_MR | M_ASB01;
    localparam logic [16:0] E_DEC    = M_ASB11;
    localparam logic [16:0] E_DECILL = M_ASB11 | M_ILL;
    localparam logic [16:0] E_MADDR  = M_ASA | M_ASB10;
    localparam logic [16:0] E_MRD    = M_MR | M_IOD;
    localparam logic [16:0] E_MWB    = M_RW | M_M2R;
    localparam logic [16:0] E_MWR    = M_MW | M_IOD;
    localparam logic [16:0] E_REX    = M_ASA | M_OP1;
    localparam logic [16:0] E_RWB    = M_RW | M_RDST;
    localparam logic [16:0] E_BR     = M_ASA | M_OP0 | M_PWC | M_PS01;
    localparam logic [16:0] E_JMP    = M_PW | M_PS10;
    localparam logic [16:0] E_IEX    = M_ASA | M_ASB10;
    localparam logic [16:0] E_IWB    = M_RW;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
    localparam logic [5:0] BEQ = 6'b000100, JMP = 6'b000010, ADDI = 6'b001000;
    localparam logic [5:0] BAD = 6'b111111;

    typedef struct packed {
        logic [3:0]  st;
        logic [16:0] ctl;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    logic [16:0] act;

    assign act = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                  mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b,
                  alu_op1, alu_op0, pc_source, illegal_op};

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            n_checks++;
            if (state_dbg == e.st) n_pass++;
            else $display("FAIL state: got %0d expected %0d at %0t", state_dbg, e.st, $time);
            n_checks++;
            if (act == e.ctl) n_pass++;
            else $display("FAIL ctl[st%0d]: got %b expected %b at %0t", e.st, act, e.ctl, $time);
            n_checks++;
            if (!(mem_read && mem_write)) n_pass++;
            else $display("FAIL rd_wr_excl: mem_read=%b mem_write=%b", mem_read, mem_write);
        end
    end

    // Drive one cycle of inputs just after the edge and queue what that cycle must show.
    task automatic step(input logic [5:0] op, input logic rdy, input logic [3:0] st,
                        input logic [16:0] ctl);
        opcode    = op;
        mem_ready = rdy;
        q.push_back('{st: st, ctl: ctl});
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; opcode = 6'h0; mem_ready = 1'b0;
        @(posedge clk); #1;
        repeat (3) step(RT, 1'b0, 4'd0, E_IDLE);
        rst_n = 1'b1;
        step(RT, 1'b1, 4'd0, E_IDLE);
        // lw, no wait states
        step(LW, 1'b1, 4'd1, E_FETCH);
        step(LW, 1'b1, 4'd2, E_DEC);
        step(LW, 1'b1, 4'd3, E_MADDR);
        step(LW, 1'b1, 4'd4, E_MRD);
        step(LW, 1'b1, 4'd5, E_MWB);
        // sw with two wait states in MEM_WR
        step(SW, 1'b1, 4'd1, E_FETCH);
        step(SW, 1'b1, 4'd2, E_DEC);
        step(SW, 1'b1, 4'd3, E_MADDR);
        step(SW, 1'b0, 4'd6, E_MWR);
        step(SW, 1'b0, 4'd6, E_MWR);
        step(SW, 1'b1, 4'd6, E_MWR);
        // R-type, beq, j, addi
        step(RT, 1'b1, 4'd1, E_FETCH);
        step(RT, 1'b1, 4'd2, E_DEC);
        step(RT, 1'b1, 4'd7, E_REX);
        step(RT, 1'b1, 4'd8, E_RWB);
        step(BEQ, 1'b1, 4'd1, E_FETCH);
        step(BEQ, 1'b1, 4'd2, E_DEC);
        step(BEQ, 1'b1, 4'd9, E_BR);
        step(JMP, 1'b1, 4'd1, E_FETCH);
        step(JMP, 1'b1, 4'd2, E_DEC);
        step(JMP, 1'b1, 4'd10, E_JMP);
        step(ADDI, 1'b1, 4'd1, E_FETCH);
        step(ADDI, 1'b1, 4'd2, E_DEC);
        step(ADDI, 1'b1, 4'd11, E_IEX);
        step(ADDI, 1'b1, 4'd12, E_IWB);
        // fetch stall, then an unsupported opcode
        repeat (4) step(BAD, 1'b0, 4'd1, E_FSTALL);
        step(BAD, 1'b1, 4'd1, E_FETCH);
        step(BAD, 1'b1, 4'd2, E_DECILL);
        // lw with a stall in MEM_RD
        step(LW, 1'b1, 4'd1, E_FETCH);
        step(LW, 1'b1, 4'd2, E_DEC);
        step(LW, 1'b1, 4'd3, E_MADDR);
        step(LW, 1'b0, 4'd4, E_MRD);
        step(LW, 1'b1, 4'd4, E_MRD);
        step(LW, 1'b1, 4'd5, E_MWB);
        // sw interrupted by reset while waiting in MEM_WR
        step(SW, 1'b1, 4'd1, E_FETCH);
        step(SW, 1'b1, 4'd2, E_DEC);
        step(SW, 1'b1, 4'd3, E_MADDR);
        opcode = SW; mem_ready = 1'b0;
        @(negedge clk); #1;
        n_checks++;
        if (mem_write === 1'b1 && state_dbg === 4'd6) n_pass++;
        else $display("FAIL pre_reset_mw: mem_write=%b state=%0d expected 1/6", mem_write, state_dbg);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (mem_write === 1'b0 && state_dbg === 4'd0 && act === E_IDLE) n_pass++;
        else $display("FAIL async_reset: mem_write=%b state=%0d ctl=%b expected 0/0/0",
                      mem_write, state_dbg, act);
        @(posedge clk); #1;
        step(SW, 1'b1, 4'd0, E_IDLE);
        rst_n = 1'b1;
        step(SW, 1'b1, 4'd0, E_IDLE);
        step(SW, 1'b1, 4'd1, E_FETCH);
        @(negedge clk); #1;
        n_checks++;
        if (q.size() == 0) n_pass++;
        else $display("FAIL queue_drain: %0d left expected 0", q.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: sim time %0t expected finish earlier", $time);
        $fatal(1, "timeout");
    end

endmodule
